// File: rtl/datapath_unit.sv
// datapath_unit: 16x16 register file, 256x16 data memory and 8-op ALU with write-back mux.
// Define DATAPATH_FLAGS_EN to add registered Z/N/C status flags.
module datapath_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  D_Addr,
  input  logic        D_Wr,
  input  logic        RF_s,
  input  logic [3:0]  RF_W_Addr,
  input  logic        RF_W_en,
  input  logic [3:0]  RF_Ra_Addr,
  input  logic [3:0]  RF_Rb_Addr,
  input  logic [2:0]  ALU_s0,
  output logic [15:0] Ra_Data,
  output logic [15:0] Rb_Data,
  output logic [15:0] ALU_Out,
  output logic [15:0] W_Data
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic        Z,
  output logic        N,
  output logic        C
`endif
);
  logic [1:0]  rst_q;
  logic        wr_ok;
  logic [15:0] rf [16];
  logic [15:0] mem [256];
  logic [15:0] rd_q, opb, sum, diff;
  // Writes stay blocked until the deassertion has passed through two flops
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign wr_ok = ~rst_q[1];
  assign Ra_Data = rf[RF_Ra_Addr];
  assign Rb_Data = rf[RF_Rb_Addr];
  assign opb = (ALU_s0 == 3'd7) ? 16'd1 : Rb_Data;
`ifdef DATAPATH_FLAGS_EN
  logic co, bo;
  assign {co, sum}  = {1'b0, Ra_Data} + {1'b0, opb};
  assign {bo, diff} = {1'b0, Ra_Data} - {1'b0, Rb_Data};
`else
  assign sum  = Ra_Data + opb;
  assign diff = Ra_Data - Rb_Data;
`endif
  assign ALU_Out = (ALU_s0 == 3'd0) ? 16'd0 :
                   (ALU_s0 == 3'd1 || ALU_s0 == 3'd7) ? sum :
                   (ALU_s0 == 3'd2) ? diff :
                   (ALU_s0 == 3'd3) ? Ra_Data :
                   (ALU_s0 == 3'd4) ? (Ra_Data ^ Rb_Data) :
                   (ALU_s0 == 3'd5) ? (Ra_Data | Rb_Data) : (Ra_Data & Rb_Data);
  assign W_Data = RF_s ? rd_q : ALU_Out;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      rf   <= '{default: '0};
      rd_q <= '0;
    end else begin
      rd_q <= mem[D_Addr];
      if (wr_ok && RF_W_en) rf[RF_W_Addr] <= W_Data;
    end
  // Memory contents survive reset
  always_ff @(posedge Clk)
    if (wr_ok && D_Wr) mem[D_Addr] <= Ra_Data;
`ifdef DATAPATH_FLAGS_EN
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Z <= 1'b0;
      N <= 1'b0;
      C <= 1'b0;
    end else if (wr_ok && RF_W_en && !RF_s) begin
      Z <= (ALU_Out == 16'd0);
      N <= ALU_Out[15];
      C <= (ALU_s0 == 3'd1 || ALU_s0 == 3'd7) ? co : (ALU_s0 == 3'd2) ? bo : 1'b0;
    end
`endif
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: directed vectors plus a behavioural model compared every negative clock edge.
module tb_datapath_unit;
  logic Clk = 1'b0, Reset = 1'b1;
  logic [7:0] D_Addr = '0;
  logic D_Wr = 1'b0, RF_s = 1'b0, RF_W_en = 1'b0;
  logic [3:0] RF_W_Addr = '0, RF_Ra_Addr = '0, RF_Rb_Addr = '0;
  logic [2:0] ALU_s0 = '0;
  logic [15:0] Ra_Data, Rb_Data, ALU_Out, W_Data;
`ifdef DATAPATH_FLAGS_EN
  logic Z, N, C;
`endif
  int checks = 0, failures = 0;
  bit cmp_on = 0;

  datapath_unit dut (
    .Clk(Clk), .Reset(Reset), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0), .Ra_Data(Ra_Data), .Rb_Data(Rb_Data),
    .ALU_Out(ALU_Out), .W_Data(W_Data)
`ifdef DATAPATH_FLAGS_EN
    , .Z(Z), .N(N), .C(C)
`endif
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: arrays of register and memory values, result = {carry/borrow, 16-bit value}
  logic [15:0] rf_m [16];
  logic [15:0] mem_m [int];
  logic [15:0] rdq_m;
  bit rdq_k, z_m, n_m, c_m;
  int rel;

  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return 17'd0;
      3'd1: return {1'b0, a} + {1'b0, b};
      3'd2: return {1'b0, a} - {1'b0, b};
      3'd3: return {1'b0, a};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a & b};
      default: return {1'b0, a} + 17'd1;
    endcase
  endfunction

  always @(posedge Clk or posedge Reset) begin : model
    logic [16:0] r;
    logic [15:0] a, wd, rd_n;
    bit rd_k;
    if (Reset) begin
      foreach (rf_m[i]) rf_m[i] = '0;
      rdq_m = '0; rdq_k = 1; z_m = 0; n_m = 0; c_m = 0; rel = 0;
    end else begin
      a = rf_m[RF_Ra_Addr];
      r = alu_f(ALU_s0, a, rf_m[RF_Rb_Addr]);
      wd = RF_s ? rdq_m : r[15:0];
      rd_k = mem_m.exists(int'(D_Addr));
      rd_n = rd_k ? mem_m[int'(D_Addr)] : 16'd0;
      if (rel >= 1) begin
        if (D_Wr) mem_m[int'(D_Addr)] = a;
        if (RF_W_en) rf_m[RF_W_Addr] = wd;
        if (RF_W_en && !RF_s) begin
          z_m = (r[15:0] == 16'd0);
          n_m = r[15];
          c_m = r[16];
        end
      end
      rdq_m = rd_n;
      rdq_k = rd_k;
      if (rel < 3) rel++;
    end
  end

  always @(negedge Clk) begin : compare
    logic [16:0] r;
    if (cmp_on) begin
      r = alu_f(ALU_s0, rf_m[RF_Ra_Addr], rf_m[RF_Rb_Addr]);
      chk("m_ra", Ra_Data, rf_m[RF_Ra_Addr]);
      chk("m_rb", Rb_Data, rf_m[RF_Rb_Addr]);
      chk("m_alu", ALU_Out, r[15:0]);
      if (!RF_s || rdq_k) chk("m_wdata", W_Data, RF_s ? rdq_m : r[15:0]);
`ifdef DATAPATH_FLAGS_EN
      chk("m_z", {15'd0, Z}, {15'd0, z_m});
      chk("m_n", {15'd0, N}, {15'd0, n_m});
      chk("m_c", {15'd0, C}, {15'd0, c_m});
`endif
    end
  end

  task automatic step(); @(posedge Clk); #1; endtask
  task automatic look(); @(negedge Clk); endtask

  logic [15:0] exp_alu [8] = '{16'h0000, 16'h0001, 16'hFFFD, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h0002, 16'h0000};

  initial begin
    repeat (2) step();
    cmp_on = 1;
    look();
    chk("rst_alu", ALU_Out, 16'h0000);
    chk("rst_wdata", W_Data, 16'h0000);
    step();
    Reset = 0;
    ALU_s0 = 3'd7; RF_W_Addr = 4'd6; RF_W_en = 1;
    step();
    RF_W_en = 0; ALU_s0 = 3'd0;
    repeat (2) step();
    RF_Ra_Addr = 4'd6;
    look();
    chk("first_edge_blocked", Ra_Data, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      RF_Ra_Addr = 4'(i); RF_Rb_Addr = 4'(15 - i);
      #1;
      chk("sweep_ra", Ra_Data, 16'h0000);
      chk("sweep_rb", Rb_Data, 16'h0000);
    end
    step();
    RF_Ra_Addr = 4'd0; RF_Rb_Addr = 4'd0; ALU_s0 = 3'd7; RF_s = 0; RF_W_Addr = 4'd1; RF_W_en = 1;
    step();
    RF_Ra_Addr = 4'd1; RF_W_Addr = 4'd2;
    step();
    RF_W_en = 0; RF_Rb_Addr = 4'd2;
    look();
    chk("r1", Ra_Data, 16'h0001);
    chk("r2", Rb_Data, 16'h0002);
    ALU_s0 = 3'd2; RF_W_Addr = 4'd3; RF_W_en = 1;
    look();
    chk("sub_alu", ALU_Out, 16'hFFFF);
    step();
    RF_W_en = 0; RF_Ra_Addr = 4'd3;
    look();
    chk("r3", Ra_Data, 16'hFFFF);
`ifdef DATAPATH_FLAGS_EN
    chk("sub_z", {15'd0, Z}, 16'd0);
    chk("sub_n", {15'd0, N}, 16'd1);
    chk("sub_c", {15'd0, C}, 16'd1);
`endif
    step();
    ALU_s0 = 3'd0; RF_W_Addr = 4'd7; RF_W_en = 1;
    step();
    RF_W_en = 0; RF_Ra_Addr = 4'd7;
    look();
    chk("r7", Ra_Data, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
    chk("zero_z", {15'd0, Z}, 16'd1);
    chk("zero_n", {15'd0, N}, 16'd0);
    chk("zero_c", {15'd0, C}, 16'd0);
`endif
    step();
    RF_Ra_Addr = 4'd3; RF_Rb_Addr = 4'd1; ALU_s0 = 3'd1; RF_W_Addr = 4'd8; RF_W_en = 1;
    look();
    chk("add_wrap", ALU_Out, 16'h0000);
    step();
    RF_W_en = 0;
`ifdef DATAPATH_FLAGS_EN
    look();
    chk("carry_c", {15'd0, C}, 16'd1);
    chk("carry_z", {15'd0, Z}, 16'd1);
    step();
`endif
    RF_Ra_Addr = 4'd2; D_Addr = 8'h1B; D_Wr = 1; ALU_s0 = 3'd0;
    step();
    D_Wr = 0; RF_s = 1;
    step();
    RF_W_Addr = 4'd5; RF_W_en = 1;
    look();
    chk("mem_wdata", W_Data, 16'h0002);
    step();
    RF_W_en = 0; RF_s = 0; RF_Ra_Addr = 4'd5;
    look();
    chk("r5", Ra_Data, 16'h0002);
    step();
    RF_Ra_Addr = 4'd2; D_Addr = 8'h40; D_Wr = 1;
    step();
    RF_Ra_Addr = 4'd1; RF_s = 1;
    step();
    D_Wr = 0;
    look();
    chk("rbw_old", W_Data, 16'h0002);
    step();
    look();
    chk("rbw_new", W_Data, 16'h0001);
    step();
    RF_s = 0; RF_Ra_Addr = 4'd1; RF_W_Addr = 4'd1; ALU_s0 = 3'd7; D_Addr = 8'h41; D_Wr = 1; RF_W_en = 1;
    look();
    chk("pre_edge_ra", Ra_Data, 16'h0001);
    step();
    RF_W_en = 0; D_Wr = 0;
    chk("post_edge_ra", Ra_Data, 16'h0002);
    RF_s = 1;
    step();
    look();
    chk("dual_wr_mem", W_Data, 16'h0001);
    step();
    RF_s = 0; RF_Ra_Addr = 4'd3; RF_Rb_Addr = 4'd2;
    for (int op = 0; op < 8; op++) begin
      ALU_s0 = 3'(op);
      look();
      chk("alu_op", ALU_Out, exp_alu[op]);
      step();
    end
    RF_Ra_Addr = 4'd1; RF_W_Addr = 4'd4; ALU_s0 = 3'd7; RF_W_en = 1;
    look();
    #5 Reset = 1;
    #1;
    chk("async_r1", Ra_Data, 16'h0000);
    RF_Ra_Addr = 4'd5; RF_Rb_Addr = 4'd3;
    #1;
    chk("async_r5", Ra_Data, 16'h0000);
    chk("async_r3", Rb_Data, 16'h0000);
    RF_Ra_Addr = 4'd2;
    #1;
    chk("async_r2", Ra_Data, 16'h0000);
    step();
    RF_W_en = 0; RF_Ra_Addr = 4'd4;
    chk("aborted_r4", Ra_Data, 16'h0000);
    Reset = 0;
    repeat (3) step();
    D_Addr = 8'h1B; RF_s = 1;
    step();
    look();
    chk("mem_kept", W_Data, 16'h0002);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
